// File: rtl/decode.sv
// Raisin64 decode stage: splits left-justified 16/32/64-bit instruction words into fields
// behind a one-entry output register. Define RAISIN64_DECODE_SCOREBOARD_EN for hazard tracking.
module decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] inst_data,
  input  logic [63:0] inst_pc,
  input  logic        flush,
  output logic        stall,
  input  logic        ex_ready,
  output logic        dec_valid,
  output logic [7:0]  dec_op,
  output logic [5:0]  dec_rd,
  output logic [5:0]  dec_rs1,
  output logic [5:0]  dec_rs2,
  output logic [63:0] dec_imm,
  output logic [3:0]  dec_len,
  output logic        dec_we,
  output logic [63:0] dec_pc,
  input  logic        wb_valid,
  input  logic [5:0]  wb_rd
);

  logic        valid_q;
  logic [7:0]  op_q, op_d;
  logic [5:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [63:0] imm_q, imm_d, pc_q;
  logic [3:0]  len_q, len_d;
  logic        we_q, we_d;
  logic        hazard;
  logic        load;
  logic        bubble;

  // Field extraction for the word currently presented by fetch
  always_comb begin
    op_d  = 8'd0;
    rd_d  = 6'd0;
    rs1_d = 6'd0;
    rs2_d = 6'd0;
    imm_d = 64'd0;
    len_d = 4'd2;
    we_d  = 1'b0;
    case (inst_data[63:62])
      2'b10: begin
        op_d  = {2'b10, inst_data[61:56]};
        rd_d  = inst_data[55:50];
        rs1_d = inst_data[49:44];
        rs2_d = inst_data[43:38];
        imm_d = {{52{inst_data[43]}}, inst_data[43:32]};
        len_d = 4'd4;
        we_d  = ~inst_data[61];
      end
      2'b11: begin
        op_d  = {2'b11, inst_data[61:56]};
        rd_d  = inst_data[55:50];
        rs1_d = inst_data[49:44];
        rs2_d = inst_data[43:38];
        imm_d = {{32{inst_data[31]}}, inst_data[31:0]};
        len_d = 4'd8;
        we_d  = ~inst_data[61];
      end
      default: begin
        op_d  = {5'd0, inst_data[62:60]};
        rd_d  = inst_data[59:54];
        rs1_d = inst_data[59:54];
        rs2_d = inst_data[53:48];
        imm_d = 64'd0;
        len_d = 4'd2;
        we_d  = 1'b1;
      end
    endcase
    if (rd_d == 6'd0) begin
      we_d = 1'b0;
    end else begin
      we_d = we_d;
    end
  end

  assign bubble = (inst_data == 64'd0);

`ifdef RAISIN64_DECODE_SCOREBOARD_EN
  logic [63:0] pending_q, pending_d;
  logic [63:0] wb_clear, set_mask, busy_mask;

  // Retiring registers are bypassed; the entry in the output register counts as busy too
  always_comb begin
    wb_clear  = wb_valid ? (64'd1 << wb_rd) : 64'd0;
    set_mask  = (valid_q & ex_ready & we_q & ~flush) ? (64'd1 << rd_q) : 64'd0;
    busy_mask = (pending_q & ~wb_clear) | ((valid_q & we_q) ? (64'd1 << rd_q) : 64'd0);
    pending_d = (pending_q & ~wb_clear) | set_mask;
    hazard    = ~bubble & (busy_mask[rs1_d] | busy_mask[rs2_d] | (we_d & busy_mask[rd_d]));
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 64'd0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  assign stall = ~flush & (hazard | (valid_q & ~ex_ready));
  assign load  = ~stall & ~flush & ~bubble;

  // Output register: flush kills, load replaces, a transfer with nothing behind it empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= 8'd0;
      rd_q    <= 6'd0;
      rs1_q   <= 6'd0;
      rs2_q   <= 6'd0;
      imm_q   <= 64'd0;
      len_q   <= 4'd0;
      we_q    <= 1'b0;
      pc_q    <= 64'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      len_q   <= len_d;
      we_q    <= we_d;
      pc_q    <= inst_pc;
    end else if (valid_q & ex_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign dec_valid = valid_q;
  assign dec_op    = op_q;
  assign dec_rd    = rd_q;
  assign dec_rs1   = rs1_q;
  assign dec_rs2   = rs2_q;
  assign dec_imm   = imm_q;
  assign dec_len   = len_q;
  assign dec_we    = we_q;
  assign dec_pc    = pc_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the Raisin64 decode stage; scoreboard expectations follow
// RAISIN64_DECODE_SCOREBOARD_EN.
module tb_decode;

  logic        clk;
  logic        rst_n;
  logic [63:0] inst_data;
  logic [63:0] inst_pc;
  logic        flush;
  logic        stall;
  logic        ex_ready;
  logic        dec_valid;
  logic [7:0]  dec_op;
  logic [5:0]  dec_rd;
  logic [5:0]  dec_rs1;
  logic [5:0]  dec_rs2;
  logic [63:0] dec_imm;
  logic [3:0]  dec_len;
  logic        dec_we;
  logic [63:0] dec_pc;
  logic        wb_valid;
  logic [5:0]  wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] V1 = 64'h8A1C_1234_0000_0000; // 32b op 0A rd7 rs1 1 rs2 8 imm 0x234
  localparam logic [63:0] V2 = 64'hC50C_2100_FFFF_FFFE; // 64b op 05 rd3 rs1 2 rs2 4 imm -2
  localparam logic [63:0] V3 = 64'h324A_0000_0000_0000; // 16b op 3 rd9 rs2 10
  localparam logic [63:0] V4 = 64'hA110_6800_0000_0000; // 32b store op 21 rd4 rs1 6 rs2 32 imm 0x800
  localparam logic [63:0] V5 = 64'h1000_0000_0000_0000; // 16b op 1 rd0
  localparam logic [63:0] W5 = 64'h1140_0000_0000_0000; // 16b writer of r5
  localparam logic [63:0] W2 = 64'h1080_0000_0000_0000; // 16b writer of r2
  localparam logic [63:0] R5 = 64'hA100_5000_0000_0000; // 32b store reading r5
  localparam logic [63:0] R2 = 64'hA100_2000_0000_0000; // 32b store reading r2

  decode dut (
    .clk(clk), .rst_n(rst_n), .inst_data(inst_data), .inst_pc(inst_pc),
    .flush(flush), .stall(stall), .ex_ready(ex_ready), .dec_valid(dec_valid),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_len(dec_len), .dec_we(dec_we), .dec_pc(dec_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_fields(input string tag, input logic [7:0] op, input logic [5:0] rd,
                              input logic [5:0] rs1, input logic [5:0] rs2, input logic [63:0] imm,
                              input logic [3:0] len, input logic we, input logic [63:0] pc);
    check_eq({tag, "_valid"}, {63'd0, dec_valid}, 64'd1);
    check_eq({tag, "_op"}, {56'd0, dec_op}, {56'd0, op});
    check_eq({tag, "_rd"}, {58'd0, dec_rd}, {58'd0, rd});
    check_eq({tag, "_rs1"}, {58'd0, dec_rs1}, {58'd0, rs1});
    check_eq({tag, "_rs2"}, {58'd0, dec_rs2}, {58'd0, rs2});
    check_eq({tag, "_imm"}, dec_imm, imm);
    check_eq({tag, "_len"}, {60'd0, dec_len}, {60'd0, len});
    check_eq({tag, "_we"}, {63'd0, dec_we}, {63'd0, we});
    check_eq({tag, "_pc"}, dec_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0; inst_data = 64'd0; inst_pc = 64'd0; flush = 1'b0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 6'd0;
    #12;
    check_eq("rst_valid", {63'd0, dec_valid}, 64'd0);
    check_eq("rst_stall", {63'd0, stall}, 64'd0);
    check_eq("rst_op", {56'd0, dec_op}, 64'd0);
    check_eq("rst_imm", dec_imm, 64'd0);
    check_eq("rst_we", {63'd0, dec_we}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Field decode, one instruction per cycle
    inst_data = V1; inst_pc = 64'h1000;
    #1 check_eq("v1_stall", {63'd0, stall}, 64'd0);
    tick();
    check_fields("v1", 8'h8A, 6'd7, 6'd1, 6'd8, 64'h234, 4'd4, 1'b1, 64'h1000);
    inst_data = V2; inst_pc = 64'h1004;
    tick();
    check_fields("v2", 8'hC5, 6'd3, 6'd2, 6'd4, 64'hFFFF_FFFF_FFFF_FFFE, 4'd8, 1'b1, 64'h1004);
    inst_data = V3; inst_pc = 64'h100C;
    tick();
    check_fields("v3", 8'h03, 6'd9, 6'd9, 6'd10, 64'd0, 4'd2, 1'b1, 64'h100C);
    inst_data = V4; inst_pc = 64'h100E;
    tick();
    check_fields("v4", 8'hA1, 6'd4, 6'd6, 6'd32, 64'hFFFF_FFFF_FFFF_F800, 4'd4, 1'b0, 64'h100E);
    inst_data = V5; inst_pc = 64'h1012;
    tick();
    check_fields("v5", 8'h01, 6'd0, 6'd0, 6'd0, 64'd0, 4'd2, 1'b0, 64'h1012);
    inst_data = 64'd0;
    tick();
    check_eq("bubble_valid", {63'd0, dec_valid}, 64'd0);

    // Backpressure: held entry is stable, then exactly one transfer
    do_reset();
    inst_data = V3; inst_pc = 64'h2000;
    tick();
    ex_ready = 1'b0; inst_data = V1; inst_pc = 64'h2002;
    #1 check_eq("bp_stall0", {63'd0, stall}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_op", {56'd0, dec_op}, 64'h03);
      check_eq("bp_rd", {58'd0, dec_rd}, 64'd9);
      check_eq("bp_pc", dec_pc, 64'h2000);
      check_eq("bp_valid", {63'd0, dec_valid}, 64'd1);
      check_eq("bp_stall", {63'd0, stall}, 64'd1);
    end
    ex_ready = 1'b1;
    #1 check_eq("bp_release", {63'd0, stall}, 64'd0);
    tick();
    check_eq("bp_next_op", {56'd0, dec_op}, 64'h8A);
    inst_data = 64'd0;
    tick();

    // RAW hazard on r5
    do_reset();
    inst_data = W5; inst_pc = 64'h3000;
    tick();
    check_eq("raw_w_rd", {58'd0, dec_rd}, 64'd5);
    inst_data = R5; inst_pc = 64'h3002;
`ifdef RAISIN64_DECODE_SCOREBOARD_EN
    #1 check_eq("raw_stall_a", {63'd0, stall}, 64'd1);
    tick();
    check_eq("raw_empty", {63'd0, dec_valid}, 64'd0);
    check_eq("raw_stall_b", {63'd0, stall}, 64'd1);
    tick();
    check_eq("raw_stall_c", {63'd0, stall}, 64'd1);
    wb_valid = 1'b1; wb_rd = 6'd5;
    #1 check_eq("raw_bypass", {63'd0, stall}, 64'd0);
    tick();
    wb_valid = 1'b0;
`else
    #1 check_eq("raw_stall_a", {63'd0, stall}, 64'd0);
    tick();
`endif
    check_eq("raw_load_op", {56'd0, dec_op}, 64'hA1);
    check_eq("raw_load_rs1", {58'd0, dec_rs1}, 64'd5);
    check_eq("raw_load_valid", {63'd0, dec_valid}, 64'd1);
    inst_data = 64'd0;
    tick();

    // Flush kills a held writer without touching older pending bits
    do_reset();
    inst_data = W2; inst_pc = 64'h4000;
    tick();
    inst_data = W5; inst_pc = 64'h4002;
    tick();
    inst_data = R5; inst_pc = 64'h4004; flush = 1'b1;
    #1 check_eq("fl_stall", {63'd0, stall}, 64'd0);
    tick();
    flush = 1'b0;
    check_eq("fl_valid", {63'd0, dec_valid}, 64'd0);
    #1 check_eq("fl_killed_rd", {63'd0, stall}, 64'd0);
    tick();
    check_eq("fl_load_op", {56'd0, dec_op}, 64'hA1);
    inst_data = R2; inst_pc = 64'h4008;
`ifdef RAISIN64_DECODE_SCOREBOARD_EN
    #1 check_eq("fl_pending_kept", {63'd0, stall}, 64'd1);
    wb_valid = 1'b1; wb_rd = 6'd2;
    #1 check_eq("fl_wb_clear", {63'd0, stall}, 64'd0);
    tick();
    wb_valid = 1'b0;
`else
    #1 check_eq("fl_pending_kept", {63'd0, stall}, 64'd0);
    tick();
`endif
    check_eq("fl_r2_rs1", {58'd0, dec_rs1}, 64'd2);

    // Asynchronous reset mid-operation
    inst_data = W5; inst_pc = 64'h5000;
    tick();
    inst_data = V1; inst_pc = 64'h5002;
    tick();
    check_eq("mr_pre_valid", {63'd0, dec_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", {63'd0, dec_valid}, 64'd0);
    check_eq("mr_op", {56'd0, dec_op}, 64'd0);
    check_eq("mr_we", {63'd0, dec_we}, 64'd0);
    rst_n = 1'b1;
    inst_data = R5; inst_pc = 64'h5010;
    #1 check_eq("mr_pending_clear", {63'd0, stall}, 64'd0);
    tick();
    check_eq("mr_load_op", {56'd0, dec_op}, 64'hA1);
    inst_data = 64'd0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
